uart_result_tx: RTL
===================

# uart_result_tx

Serialises the 64-bit puzzle result onto the board's UART output line as 8 bytes, most-significant byte first. Framing is 8E1: 1 start bit, 8 data bits LSB-first, even parity, 1 stop bit. It is the output stage after the solver core: it latches the result on a one-cycle `start` pulse and drives `uart_rxd_out` until the last stop bit finishes. It also exposes a per-byte strobe for bench monitoring.

## Interface
- `CLK_FREQ`, 12_000_000, system clock frequency in Hz.
- `BAUD_RATE`, 38_400, line rate in bit/s.
- `NUM_BYTES`, 8, bytes per result (1..8).
- `sysclk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to transmit `result`.
- `result`  in  64  value to send; sampled only in the cycle `start` is accepted.
- `busy`  out  1  high while a transmission is in progress.
- `done`  out  1  one-cycle pulse when the final stop bit completes.
- `clk_out`  out  1  one-cycle pulse at the start of each byte's start bit.
- `tx_out`  out  8  byte currently being framed; valid from `clk_out` until the next `clk_out`.
- `uart_rxd_out`  out  1  serial line; idles high.

## Operation
- Definitions:
  - CPB = CLK_FREQ / BAUD_RATE, using integer division (312 at the defaults).
  - One frame = 11 bits = 11·CPB cycles.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Line is 1.
  - A `start` with `busy`=0 loads a 64-bit shift register from `result` and sets the byte counter to NUM_BYTES-1.
  - The next state is START.
- Byte selection: byte k is `result[8·k+7:8·k]`. Bytes are sent for k = NUM_BYTES-1 down to 0, so the MSB byte goes first.
- START:
  - Line is 0 for CPB cycles.
  - On entry: load `tx_out` with the current byte, pulse `clk_out`, and latch parity = XOR of the byte's 8 bits.
- DATA:
  - 8 bits, LSB first, each held for CPB cycles.
  - A 3-bit bit index wraps from 7 to PARITY.
- PARITY: line = latched parity, which makes the total count of ones in data+parity even.
- STOP:
  - Line is 1 for CPB cycles.
  - If byte counter ≠ 0: decrement it and go to START with no idle gap.
  - Otherwise go to IDLE and pulse `done`.
- `start` while `busy`=1 is ignored. The in-flight transfer and its latched value are unaffected.
- `result` changes after acceptance have no effect.
- Baud counter:
  - Counts 0..CPB-1 and is cleared on every state change.
  - Width is clog2(CPB).
  - No fractional-rate compensation; the 0.16 % error at the defaults is accepted.

## Timing
- Reset values:
  - `uart_rxd_out`=1, `busy`=0, `done`=0, `clk_out`=0, `tx_out`=0x00.
  - State is IDLE; all counters and the shift register are 0.
- Reset asserted mid-frame: on the next edge the line returns to 1 and all outputs take their reset values. No partial byte is completed.
- All outputs are registered.
- Acceptance and line timing, with `start` sampled at edge t:
  - `busy`=1 and `uart_rxd_out`=0 from t+1.
  - `clk_out`=1 for cycle t+1 only.
- Every bit lasts exactly CPB cycles.
- Byte n's start bit begins at t+1+n·11·CPB.
- End of transfer:
  - `done`=1 and `busy`=0 in cycle t+1+NUM_BYTES·11·CPB. This is 27_457 cycles after t at the defaults.
  - `done` lasts one cycle.
- Back-to-back: `start` in the same cycle `done` is high is accepted. The line goes low on the following edge, so it stays high for exactly one cycle beyond the stop bit.
- `start` and `rst` in the same cycle: reset wins and nothing is latched.

## Test plan
- Reset, then idle for 1000 cycles → `uart_rxd_out` stays 1, `busy`=0, no `clk_out` or `done` pulses.
- `start` with `result`=0x0000040C6D0C4961, bench 8E1 receiver → bytes received in order:
  - data 00 00 04 0C 6D 0C 49 61;
  - parity bits 0 0 1 0 1 0 1 1;
  - all stop bits 1.
  - `done` arrives exactly 27_457 cycles after `start`.
- Bit width check: measure the low time of the first start bit → 312 cycles. Byte 0x61 DATA pattern on the line is 1,0,0,0,0,1,1,0.
- `start` pulsed again with `result`=0xFFFF…FF at cycle t+5000 of a transfer → ignored. The original 8 bytes are unchanged and `busy` stays high until the original `done`.
- `rst` asserted in the middle of byte 3's DATA phase → line is 1 and `busy`=0 on the next edge. A fresh `start` with 0x0102030405060708 then sends 01..08 correctly.
- `start` held high on the `done` cycle of a transfer of 0xAA00…00:
  - The second transfer begins one cycle after the stop bit ends.
  - First byte is AA with parity 0.

Source files
------------

// File: rtl/uart_result_tx.sv
`default_nettype none
// uart_result_tx: sends a 64-bit result as NUM_BYTES 8E1 UART frames, most-significant byte first.
module uart_result_tx #(
    parameter int CLK_FREQ  = 12_000_000,
    parameter int BAUD_RATE = 38_400,
    parameter int NUM_BYTES = 8
) (
    input  logic        sysclk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] result,
    output logic        busy,
    output logic        done,
    output logic        clk_out,
    output logic [7:0]  tx_out,
    output logic        uart_rxd_out
);
    localparam int               CPB       = CLK_FREQ / BAUD_RATE;
    localparam int               CNT_W     = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CPB - 1);
    localparam int               ALIGN     = 8 * (8 - NUM_BYTES);
    localparam logic [2:0]       LAST_BYTE = 3'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] baud_q;
    logic [2:0]       bit_q;
    logic [2:0]       byte_q;
    logic [63:0]      shreg_q;
    logic [7:0]       tx_q;
    logic             parity_q;
    logic             line_q;
    logic             busy_q;
    logic             done_q;
    logic             clk_out_q;

    logic [63:0]      load_d;
    logic [7:0]       next_byte_d;
    logic             baud_wrap_d;

    // The result is left-aligned so the byte to send next always sits in the top 8 bits.
    always_comb begin
        load_d      = result << ALIGN;
        next_byte_d = (state_q == S_IDLE) ? load_d[63:56] : shreg_q[63:56];
        baud_wrap_d = (baud_q == BAUD_LAST);
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            shreg_q   <= '0;
            tx_q      <= '0;
            parity_q  <= 1'b0;
            line_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            clk_out_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            clk_out_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    line_q <= 1'b1;
                    if (start) begin
                        state_q   <= S_START;
                        baud_q    <= '0;
                        byte_q    <= LAST_BYTE;
                        shreg_q   <= load_d << 8;
                        tx_q      <= next_byte_d;
                        parity_q  <= ^next_byte_d;
                        clk_out_q <= 1'b1;
                        line_q    <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                default: begin
                    if (!baud_wrap_d) begin
                        baud_q <= baud_q + 1'b1;
                    end else begin
                        baud_q <= '0;
                        case (state_q)
                            S_START: begin
                                state_q <= S_DATA;
                                bit_q   <= '0;
                                line_q  <= tx_q[0];
                            end
                            S_DATA: begin
                                if (bit_q == 3'd7) begin
                                    state_q <= S_PARITY;
                                    line_q  <= parity_q;
                                end else begin
                                    bit_q  <= bit_q + 3'd1;
                                    line_q <= tx_q[bit_q + 3'd1];
                                end
                            end
                            S_PARITY: begin
                                state_q <= S_STOP;
                                line_q  <= 1'b1;
                            end
                            default: begin
                                // End of a stop bit: chain straight into the next start bit if bytes remain.
                                if (byte_q != 3'd0) begin
                                    state_q   <= S_START;
                                    byte_q    <= byte_q - 3'd1;
                                    shreg_q   <= shreg_q << 8;
                                    tx_q      <= next_byte_d;
                                    parity_q  <= ^next_byte_d;
                                    clk_out_q <= 1'b1;
                                    line_q    <= 1'b0;
                                end else begin
                                    state_q <= S_IDLE;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                    line_q  <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign clk_out      = clk_out_q;
    assign tx_out       = tx_q;
    assign uart_rxd_out = line_q;

endmodule
`default_nettype wire
